// File: rtl/if_stage_if.sv
// Instruction-memory request/response bundle for the fetch stage.
// Single outstanding request; address held until rvalid is seen.
interface if_stage_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, single-outstanding imem request,
// IF/ID register with stall, flush, redirect and NOP bubbles.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    if_stage_if.master  imem,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc4_o,
    output logic        ifid_valid_o
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DROP  = 2'd1,
        S_BUF   = 2'd2
    } state_t;

    state_t      r_state, w_state;
    logic [31:0] r_pc, w_pc;
    logic [31:0] r_buf, w_buf;
    logic [31:0] r_drop_addr, w_drop_addr;
    logic [31:0] r_instr, w_instr;
    logic [31:0] r_pc4, w_pc4;
    logic        r_valid, w_valid;
    logic [31:0] w_pc_inc;
    logic        w_rvalid;
    logic        w_unused_ok;

    assign w_pc_inc    = r_pc + 32'd4;
    assign w_rvalid    = imem.imem_rvalid_i;
    assign w_unused_ok = ^redirect_pc_i[1:0];

    // DROP keeps presenting the abandoned address until its response lands
    assign imem.imem_req_o  = rst_n && (r_state != S_BUF);
    assign imem.imem_addr_o = (r_state == S_DROP) ? r_drop_addr : r_pc;

    assign ifid_instr_o = r_instr;
    assign ifid_pc4_o   = r_pc4;
    assign ifid_valid_o = r_valid;

    always_comb begin
        w_state     = r_state;
        w_pc        = r_pc;
        w_buf       = r_buf;
        w_drop_addr = r_drop_addr;
        w_instr     = r_instr;
        w_pc4       = r_pc4;
        w_valid     = r_valid;

        if (redirect_valid_i) begin
            w_pc  = {redirect_pc_i[31:2], 2'b00};
            w_buf = 32'd0;
            if (r_state != S_BUF && !w_rvalid) begin
                w_state     = S_DROP;
                w_drop_addr = imem.imem_addr_o;
            end else begin
                w_state = S_FETCH;
            end
            if (!stall_i) begin
                w_instr = NOP_WORD;
                w_pc4   = w_pc_inc;
                w_valid = 1'b0;
            end
        end else begin
            unique case (r_state)
                S_FETCH: begin
                    if (w_rvalid && stall_i) begin
                        w_buf   = imem.imem_rdata_i;
                        w_state = S_BUF;
                    end else if (w_rvalid) begin
                        w_instr = imem.imem_rdata_i;
                        w_pc4   = w_pc_inc;
                        w_valid = 1'b1;
                        w_pc    = w_pc_inc;
                    end else if (!stall_i) begin
                        w_instr = NOP_WORD;
                        w_pc4   = w_pc_inc;
                        w_valid = 1'b0;
                    end
                end
                S_DROP: begin
                    if (w_rvalid) w_state = S_FETCH;
                    if (!stall_i) begin
                        w_instr = NOP_WORD;
                        w_pc4   = w_pc_inc;
                        w_valid = 1'b0;
                    end
                end
                S_BUF: begin
                    if (!stall_i) begin
                        w_instr = r_buf;
                        w_pc4   = w_pc_inc;
                        w_valid = 1'b1;
                        w_pc    = w_pc_inc;
                        w_state = S_FETCH;
                    end
                end
                default: w_state = S_FETCH;
            endcase
        end

        if (flush_i) begin
            w_instr = NOP_WORD;
            w_pc4   = 32'd0;
            w_valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_buf       <= 32'd0;
            r_drop_addr <= 32'd0;
            r_instr     <= NOP_WORD;
            r_pc4       <= 32'd0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_pc        <= w_pc;
            r_buf       <= w_buf;
            r_drop_addr <= w_drop_addr;
            r_instr     <= w_instr;
            r_pc4       <= w_pc4;
            r_valid     <= w_valid;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: zero-wait and slow memory, stall,
// redirect/flush, alignment, PC wrap and reset during DROP.
module tb_if_stage;
    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] ifid_instr_o, ifid_pc4_o;
    logic        ifid_valid_o;
    logic [31:0] ifid2_instr, ifid2_pc4;
    logic        ifid2_valid;

    int n_cmp;
    int n_bad;
    int lat;
    int cnt;
    logic auto_mem;
    logic man_rvalid;

    if_stage_if mem();
    if_stage_if mem2();

    if_stage dut (
        .clk(clk), .rst_n(rst_n),
        .stall_i(stall_i), .flush_i(flush_i),
        .redirect_valid_i(redirect_valid_i),
        .redirect_pc_i(redirect_pc_i),
        .imem(mem),
        .ifid_instr_o(ifid_instr_o),
        .ifid_pc4_o(ifid_pc4_o),
        .ifid_valid_o(ifid_valid_o)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .stall_i(1'b0), .flush_i(1'b0),
        .redirect_valid_i(1'b0),
        .redirect_pc_i(32'h0),
        .imem(mem2),
        .ifid_instr_o(ifid2_instr),
        .ifid_pc4_o(ifid2_pc4),
        .ifid_valid_o(ifid2_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory: data = addr ^ A5A5_0000; auto mode waits lat cycles
    assign mem.imem_rdata_i  = mem.imem_addr_o ^ 32'hA5A5_0000;
    assign mem.imem_rvalid_i = auto_mem ?
        (mem.imem_req_o && (cnt >= lat)) : man_rvalid;
    assign mem2.imem_rdata_i  = mem2.imem_addr_o ^ 32'hA5A5_0000;
    assign mem2.imem_rvalid_i = mem2.imem_req_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 0;
        else if (mem.imem_req_o && mem.imem_rvalid_i) cnt <= 0;
        else if (mem.imem_req_o) cnt <= cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        redirect_valid_i = 1'b0; redirect_pc_i = 32'h0;
        lat = 0; auto_mem = 1'b1; man_rvalid = 1'b0;
        #1;
        chk("rst_req", {31'd0, mem.imem_req_o}, 32'd0);
        chk("rst_instr", ifid_instr_o, 32'h0);
        chk("rst_pc4", ifid_pc4_o, 32'h0);
        chk("rst_valid", {31'd0, ifid_valid_o}, 32'd0);
        tick(); tick();
        chk("rst_req2", {31'd0, mem.imem_req_o}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("first_req", {31'd0, mem.imem_req_o}, 32'd1);
        chk("first_addr", mem.imem_addr_o, 32'h0);
        chk("wrap_addr0", mem2.imem_addr_o, 32'hFFFF_FFFC);

        // zero-wait: one instruction per cycle
        tick();
        chk("zw_instr0", ifid_instr_o, 32'hA5A5_0000);
        chk("zw_pc4_0", ifid_pc4_o, 32'h4);
        chk("zw_valid0", {31'd0, ifid_valid_o}, 32'd1);
        chk("wrap_addr1", mem2.imem_addr_o, 32'h0);
        chk("wrap_pc4", ifid2_pc4, 32'h0);
        tick();
        chk("zw_instr1", ifid_instr_o, 32'hA5A5_0004);
        chk("zw_pc4_1", ifid_pc4_o, 32'h8);
        tick();
        chk("zw_pc4_2", ifid_pc4_o, 32'hC);
        chk("zw_valid2", {31'd0, ifid_valid_o}, 32'd1);

        // two-cycle latency at PC 0xC
        lat = 2;
        tick();
        chk("lat_bub_v", {31'd0, ifid_valid_o}, 32'd0);
        chk("lat_bub_i", ifid_instr_o, 32'h0);
        chk("lat_addr1", mem.imem_addr_o, 32'hC);
        tick();
        chk("lat_addr2", mem.imem_addr_o, 32'hC);
        chk("lat_bub_v2", {31'd0, ifid_valid_o}, 32'd0);
        tick();
        chk("lat_instr", ifid_instr_o, 32'hA5A5_000C);
        chk("lat_pc4", ifid_pc4_o, 32'h10);
        chk("lat_valid", {31'd0, ifid_valid_o}, 32'd1);
        chk("lat_addr3", mem.imem_addr_o, 32'h10);

        // stall three cycles coinciding with the 0x10 response
        tick(); tick();
        chk("pre_stall_rv", {31'd0, mem.imem_rvalid_i}, 32'd1);
        chk("pre_stall_pc4", ifid_pc4_o, 32'h14);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("buf_req", {31'd0, mem.imem_req_o}, 32'd0);
            chk("buf_valid", {31'd0, ifid_valid_o}, 32'd0);
            chk("buf_pc4", ifid_pc4_o, 32'h14);
        end
        stall_i = 1'b0;
        tick();
        chk("unstall_instr", ifid_instr_o, 32'hA5A5_0010);
        chk("unstall_pc4", ifid_pc4_o, 32'h14);
        chk("unstall_valid", {31'd0, ifid_valid_o}, 32'd1);
        chk("unstall_addr", mem.imem_addr_o, 32'h14);

        // manual memory: walk to 0x20, then leave it outstanding
        auto_mem = 1'b0; man_rvalid = 1'b1;
        tick(); tick(); tick();
        chk("walk_pc4", ifid_pc4_o, 32'h20);
        man_rvalid = 1'b0;
        tick();
        chk("out_addr", mem.imem_addr_o, 32'h20);
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h40; flush_i = 1'b1;
        tick();
        redirect_valid_i = 1'b0; flush_i = 1'b0;
        chk("flush_valid", {31'd0, ifid_valid_o}, 32'd0);
        chk("flush_instr", ifid_instr_o, 32'h0);
        chk("flush_pc4", ifid_pc4_o, 32'h0);
        chk("drop_addr", mem.imem_addr_o, 32'h20);
        chk("drop_req", {31'd0, mem.imem_req_o}, 32'd1);
        man_rvalid = 1'b1;
        tick();
        chk("late_disc_v", {31'd0, ifid_valid_o}, 32'd0);
        chk("redir_addr", mem.imem_addr_o, 32'h40);
        tick();
        chk("redir_instr", ifid_instr_o, 32'hA5A5_0040);
        chk("redir_pc4", ifid_pc4_o, 32'h44);
        chk("redir_valid", {31'd0, ifid_valid_o}, 32'd1);

        // unaligned redirect target, response in same cycle discarded
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h103;
        tick();
        redirect_valid_i = 1'b0; man_rvalid = 1'b0;
        chk("align_addr", mem.imem_addr_o, 32'h100);
        chk("align_disc_v", {31'd0, ifid_valid_o}, 32'd0);

        // enter DROP, then reset asynchronously mid-cycle
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h200;
        tick();
        redirect_valid_i = 1'b0;
        chk("drop2_addr", mem.imem_addr_o, 32'h100);
        chk("drop2_pc4", ifid_pc4_o, 32'h104);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, mem.imem_req_o}, 32'd0);
        chk("arst_pc4", ifid_pc4_o, 32'h0);
        chk("arst_valid", {31'd0, ifid_valid_o}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rest_addr", mem.imem_addr_o, 32'h0);
        chk("rest_req", {31'd0, mem.imem_req_o}, 32'd1);
        man_rvalid = 1'b1;
        tick();
        chk("rest_pc4", ifid_pc4_o, 32'h4);
        chk("rest_valid", {31'd0, ifid_valid_o}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage with IF/ID pipeline register; sits directly upstream of the main control decoder and register file.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Registers the returned instruction word plus PC+4 for the decode stage.
- Handles hazard stalls, branch/jump redirects and pipeline flushes, and inserts NOP (32'h0000_0000) bubbles so the decoder deasserts regwrite.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_WORD, 32'h0000_0000, bubble instruction (sll $0,$0,0)

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  hazard unit hold: freeze PC and IF/ID
flush_i  in  1  squash IF/ID contents to NOP at next edge
redirect_valid_i  in  1  taken branch/jump/jr this cycle
redirect_pc_i  in  32  redirect target address
imem_req_o  out  1  instruction memory request
imem_addr_o  out  32  request word address (bits [1:0] always 00)
imem_rvalid_i  in  1  response valid; may be asserted in the same cycle as the request or later
imem_rdata_i  in  32  instruction word, valid with imem_rvalid_i
ifid_instr_o  out  32  registered instruction to decoder
ifid_pc4_o  out  32  registered PC+4 of that instruction
ifid_valid_o  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, rst_n=0):
  - pc_q=RESET_PC, state=FETCH, buf cleared.
  - ifid_instr_o=NOP_WORD, ifid_pc4_o=0, ifid_valid_o=0.
  - imem_req_o=0 while rst_n=0.
- Reset mid-request discards any outstanding response. Memory must tolerate an abandoned request.
- States:
  - FETCH: imem_req_o=1, imem_addr_o=pc_q.
  - DROP: request outstanding for a stale PC; req=1, addr held at the stale address.
  - BUF: instruction captured while stalled; req=0.
- Request rule: addr stays stable while req=1 until imem_rvalid_i is sampled high. At most one outstanding request.
- Priority per edge: redirect > stall > normal.
- FETCH, rvalid=1, stall=0, no redirect: IF/ID <= {rdata, pc_q+4, 1}; pc_q <= pc_q+4; stay in FETCH.
- FETCH, rvalid=1, stall=1, no redirect: buf <= rdata; IF/ID holds; state=BUF.
- FETCH, rvalid=0, stall=0, no redirect: IF/ID <= bubble {NOP_WORD, pc_q+4, 0}.
- FETCH, rvalid=0, stall=1, no redirect: everything holds; req stays asserted.
- BUF, stall=1: hold. BUF, stall=0: IF/ID <= {buf, pc_q+4, 1}; pc_q <= pc_q+4; state=FETCH.
- Redirect (any state): pc_q <= {redirect_pc_i[31:2], 2'b00}; buf discarded.
  - Next state is DROP if in FETCH/DROP with rvalid=0 this cycle; otherwise FETCH (any response in this cycle is discarded).
- DROP, rvalid=1: discard data; state=FETCH. DROP never writes a valid IF/ID entry.
- flush_i: IF/ID <= {NOP_WORD, 0, 0} at the next edge, overriding stall and any capture in the same cycle. PC/state follow the rules above.
- Stall without flush never changes IF/ID.
- PC arithmetic: 32-bit modulo 2^32, so 32'hFFFF_FFFC + 4 = 0.
- Latency: zero-wait memory gives one instruction per cycle. IF/ID updates one edge after the rvalid cycle.
- All ifid_* outputs are registered. imem_req_o/imem_addr_o decode from state and pc_q only, not from imem_rvalid_i.

Test Plan:
- Reset then zero-wait memory returning addr^32'hA5A5_0000 -> req=1 at addr 0 in the first cycle after reset. IF/ID shows instr 32'hA5A5_0000, pc4=4, then pc4=8, 12 on consecutive cycles, valid=1.
- 2-cycle memory latency -> bubble NOP with valid=0 between instructions. imem_addr_o stable across the wait. ifid_pc4_o increments by 4 per completed fetch.
- stall_i high for 3 cycles coinciding with rvalid at PC 0x10 -> state BUF, IF/ID unchanged for 3 cycles. On release, instr from 0x10 appears with pc4=0x14 and no refetch (req=0 during BUF).
- Redirect to 0x40 (plus flush_i) while request to 0x20 is outstanding -> IF/ID=NOP/valid=0. The late 0x20 response is discarded. Next req addr=0x40, then IF/ID pc4=0x44.
- Redirect to 0x103 -> imem_addr_o=0x100. RESET_PC=32'hFFFF_FFFC -> second fetch addr 0.
- Assert rst_n=0 mid-DROP -> outputs return to reset values asynchronously. After release, fetch restarts at RESET_PC.
